// File: rtl/reg_alu_transfer_unit_pkg.sv
// reg_alu_transfer_unit_pkg: shared width, ALU op, source-select and mode encodings
package reg_alu_transfer_unit_pkg;
  localparam int WIDTH = 4;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11} alu_op_e;
  typedef enum logic [1:0] {SRC_A = 2'b00, SRC_B = 2'b01, SRC_C = 2'b10, SRC_ZERO = 2'b11} src_e;
  typedef enum logic {MODE_ALU = 1'b0, MODE_TRANS = 1'b1} mode_e;
endpackage

// File: rtl/reg_alu_transfer_unit_alu4.sv
// alu4: combinational add/sub/and/or, results wrap modulo 2^W
module alu4
  import reg_alu_transfer_unit_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_op_e      op,
  output logic [W-1:0] res
);
  always_comb res = op == OP_ADD ? a + b : op == OP_SUB ? a - b : op == OP_AND ? a & b : a | b;
endmodule

// File: rtl/reg_alu_transfer_unit.sv
// reg_alu_transfer_unit: three button-driven registers with ALU count/capture and transfer modes
module reg_alu_transfer_unit
  import reg_alu_transfer_unit_pkg::*;
#(
  parameter int WIDTH = reg_alu_transfer_unit_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       BTN_Y,
  input  logic [15:0]      SW,
  output logic [WIDTH-1:0] debug_A,
  output logic [WIDTH-1:0] debug_B,
  output logic [WIDTH-1:0] debug_C,
  output logic [WIDTH-1:0] debug_res
);
  logic [WIDTH-1:0] a, b, c, a_nx, b_nx, c_nx, src, res;
  logic [2:0] btn_q, btn_prev, held, press;
  logic unused;
  mode_e mode;
  src_e sel;
  assign unused = ^{BTN_Y[3], SW[14:6]};
  assign mode = mode_e'(SW[15]);
  assign sel = src_e'(SW[5:4]);
  alu4 #(.W(WIDTH)) u_alu (.a(a), .b(b), .op(alu_op_e'(SW[3:2])), .res(res));
  // held masks a button that stayed high through reset until it is seen released
  assign press = btn_q & ~btn_prev & ~held;
  always_comb begin
    src = sel == SRC_A ? a : sel == SRC_B ? b : sel == SRC_C ? c : '0;
    a_nx = mode == MODE_TRANS ? src : SW[0] ? a - 1'b1 : a + 1'b1;
    b_nx = mode == MODE_TRANS ? src : SW[1] ? b - 1'b1 : b + 1'b1;
    c_nx = mode == MODE_TRANS ? src : res;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      c <= '0;
      btn_q <= '0;
      btn_prev <= '0;
      held <= '1;
    end else begin
      btn_q <= BTN_Y[2:0];
      btn_prev <= btn_q;
      held <= held & BTN_Y[2:0];
      if (press[0]) a <= a_nx;
      if (press[1]) b <= b_nx;
      if (press[2]) c <= c_nx;
    end
  end
  assign debug_A = a;
  assign debug_B = b;
  assign debug_C = c;
  assign debug_res = res;
endmodule

// File: tb/tb_reg_alu_transfer_unit.sv
// tb_reg_alu_transfer_unit: vector table plus scoreboard queue for the register/ALU/transfer unit
module tb_reg_alu_transfer_unit;
  logic clk = 0, rst_n = 0;
  logic [3:0] BTN_Y = '0;
  logic [15:0] SW = '0;
  logic [3:0] debug_A, debug_B, debug_C, debug_res;
  int tests = 0, fails = 0;

  typedef struct {
    logic [3:0] btn;
    logic [15:0] sw;
    int hold;
    logic [3:0] a, b, c, r;
  } vec_t;
  typedef struct {logic [3:0] a, b, c, r;} exp_t;
  vec_t vt[$];
  exp_t sb[$];

  reg_alu_transfer_unit dut (.clk(clk), .rst_n(rst_n), .BTN_Y(BTN_Y), .SW(SW),
    .debug_A(debug_A), .debug_B(debug_B), .debug_C(debug_C), .debug_res(debug_res));

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    cmp({tag, ".A"}, debug_A, e.a);
    cmp({tag, ".B"}, debug_B, e.b);
    cmp({tag, ".C"}, debug_C, e.c);
    cmp({tag, ".res"}, debug_res, e.r);
  endtask

  task automatic apply(input logic [3:0] btn, input logic [15:0] sw, input int hold);
    @(negedge clk);
    SW = sw;
    BTN_Y = btn;
    repeat (hold) @(negedge clk);
    BTN_Y = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic add(input logic [3:0] btn, input logic [15:0] sw, input int hold,
                     input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] r);
    vec_t v;
    v.btn = btn; v.sw = sw; v.hold = hold; v.a = a; v.b = b; v.c = c; v.r = r;
    vt.push_back(v);
  endtask

  task automatic run_step(input logic [3:0] btn, input logic [15:0] sw, input int hold,
                          input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] r, input string tag);
    exp_t e;
    e.a = a; e.b = b; e.c = c; e.r = r;
    sb.push_back(e);
    apply(btn, sw, hold);
    check_sb(tag);
  endtask

  initial begin
    add(4'b0001, 16'h0000, 1, 1, 0, 0, 1);
    add(4'b0010, 16'h0000, 1, 1, 1, 0, 2);
    add(4'b0010, 16'h0000, 1, 1, 2, 0, 3);
    add(4'b0010, 16'h0000, 1, 1, 3, 0, 4);
    add(4'b0010, 16'h0002, 1, 1, 2, 0, 3);
    add(4'b0100, 16'h0000, 1, 1, 2, 3, 3);
    add(4'b0100, 16'h0004, 1, 1, 2, 15, 15);
    add(4'b0100, 16'h0008, 1, 1, 2, 0, 0);
    add(4'b0100, 16'h000C, 1, 1, 2, 3, 3);
    add(4'b0000, 16'h0004, 0, 1, 2, 3, 15);
    add(4'b0000, 16'h0000, 0, 1, 2, 3, 3);
    add(4'b0001, 16'h8020, 1, 3, 2, 3, 5);
    add(4'b0010, 16'h8030, 1, 3, 0, 3, 3);
    add(4'b0010, 16'h8020, 1, 3, 3, 3, 6);
    add(4'b0100, 16'h8030, 1, 3, 3, 0, 6);
    add(4'b0001, 16'h0001, 1, 2, 3, 0, 5);
    add(4'b0001, 16'h0001, 1, 1, 3, 0, 4);
    add(4'b0001, 16'h0001, 1, 0, 3, 0, 3);
    add(4'b0001, 16'h0001, 1, 15, 3, 0, 2);
    add(4'b0100, 16'h8020, 1, 15, 3, 0, 2);
    add(4'b0010, 16'h8010, 1, 15, 3, 0, 2);
    add(4'b0001, 16'h8000, 1, 15, 3, 0, 2);
    add(4'b0100, 16'h8010, 1, 15, 3, 3, 2);
    add(4'b0100, 16'h8000, 1, 15, 3, 15, 2);
    add(4'b0010, 16'h8000, 1, 15, 15, 15, 14);
    add(4'b1000, 16'h7FC0, 1, 15, 15, 15, 14);

    repeat (3) @(negedge clk);
    cmp("reset.A", debug_A, 0);
    cmp("reset.B", debug_B, 0);
    cmp("reset.C", debug_C, 0);
    cmp("reset.res", debug_res, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vt.size(); i++)
      run_step(vt[i].btn, vt[i].sw, vt[i].hold, vt[i].a, vt[i].b, vt[i].c, vt[i].r,
               $sformatf("vec%0d", i));

    run_step(4'b0001, 16'h0000, 5, 0, 15, 15, 15, "hold5");
    run_step(4'b0001, 16'h0000, 1, 1, 15, 15, 0, "incA");
    run_step(4'b0011, 16'h8000, 1, 1, 1, 15, 2, "simul_trans");
    run_step(4'b0101, 16'h0000, 1, 2, 1, 2, 3, "simul_alu");

    @(negedge clk);
    BTN_Y = 4'b0001;
    @(negedge clk);
    rst_n = 0;
    #1;
    cmp("midrst.A", debug_A, 0);
    cmp("midrst.B", debug_B, 0);
    cmp("midrst.C", debug_C, 0);
    cmp("midrst.res", debug_res, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    cmp("heldrst.A", debug_A, 0);
    BTN_Y = '0;
    repeat (2) @(negedge clk);
    run_step(4'b0001, 16'h0000, 1, 1, 0, 0, 1, "repress");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
